// File: rtl/uart_comm.sv
// Quadcopter-side serial command link: 8N1 UART receiver feeding a 3-byte
// packet decoder (cmd, data hi, data lo) plus an independent 1-byte response transmitter.
module uart_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} pkt_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  rx_state_e  rx_state_q;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0] rx_idx_q;
  logic [7:0] rx_byte_q;
  logic       rx_done_q;

  pkt_state_e pkt_state_q;
  logic       set_q;
  logic       cmd_rdy_q;
  logic [7:0] cmd_q;
  logic [15:0] data_q;

  tx_state_e  tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0] tx_idx_q;
  logic [7:0] tx_data_q;
  logic       tx_q;
  logic       resp_sent_q;

  // Receiver: bits sampled at mid-bit, byte reported at mid-stop-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_byte_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_done_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= HALF_BIT;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= FULL_BIT;
            rx_idx_q   <= '0;
            rx_state_q <= RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
            rx_cnt_q  <= FULL_BIT;
            rx_idx_q  <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_done_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Packet framing is by byte count only; a set on the same cycle as clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_state_q <= WAIT_CMD;
      set_q       <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      cmd_q       <= '0;
      data_q      <= '0;
    end else begin
      set_q <= 1'b0;
      if (set_q)            cmd_rdy_q <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      if (rx_done_q) begin
        case (pkt_state_q)
          WAIT_CMD: begin
            cmd_q       <= rx_byte_q;
            cmd_rdy_q   <= 1'b0;
            pkt_state_q <= WAIT_HI;
          end
          WAIT_HI: begin
            data_q[15:8] <= rx_byte_q;
            pkt_state_q  <= WAIT_LO;
          end
          WAIT_LO: begin
            data_q[7:0] <= rx_byte_q;
            set_q       <= 1'b1;
            pkt_state_q <= WAIT_CMD;
          end
          default: pkt_state_q <= WAIT_CMD;
        endcase
      end
    end
  end

  // Transmitter: resp latched on send_resp while idle; requests while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data_q   <= resp;
            resp_sent_q <= 1'b0;
            tx_q        <= 1'b0;
            tx_cnt_q    <= FULL_BIT;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_q       <= tx_data_q[0];
            tx_idx_q   <= '0;
            tx_cnt_q   <= FULL_BIT;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= FULL_BIT;
            if (tx_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q     <= tx_data_q[tx_idx_q + 3'd1];
              tx_idx_q <= tx_idx_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == '0) begin
            resp_sent_q <= 1'b1;
            tx_state_q  <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign TX        = tx_q;
  assign resp_sent = resp_sent_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign cmd       = cmd_q;
  assign data      = data_q;

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm: drives serial packets on RX, decodes TX, and checks
// outputs each cycle against a frame/packet model plus literal expectations.
module tb_uart_comm;
  localparam int B = 32;

  logic        clk = 1'b0;
  logic        rst, RX, TX, send_resp, resp_sent, cmd_rdy, clr_cmd_rdy;
  logic [7:0]  resp, cmd;
  logic [15:0] data;

  always #5 clk = ~clk;

  uart_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .cmd_rdy(cmd_rdy),
    .cmd(cmd), .data(data), .clr_cmd_rdy(clr_cmd_rdy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [7:0] c; logic [15:0] d;} pkt_t;
  pkt_t exp_q[$];
  pkt_t cur_pkt;
  bit   have_pkt = 0;
  int   rise_cnt = 0;
  logic prev_rdy = 0;

  bit         tx_act = 0;
  int         tx_n = 0;
  logic [9:0] frame;
  logic       model_sent = 0;
  logic [7:0] dec = 0, last_dec = 0;

  // Model: a response frame is {stop, resp, start}, each bit B cycles wide,
  // starting the cycle after send_resp is accepted; resp_sent rises after 10 bits.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_act = 0; model_sent = 0; have_pkt = 0; prev_rdy = 0;
        exp_q.delete();
      end else begin
        if (tx_act) begin
          tx_n++;
          chk("tx_bit", TX, (tx_n >= 10*B) ? 1 : frame[tx_n/B]);
          chk("resp_sent_busy", resp_sent, (tx_n >= 10*B) ? 1 : 0);
          if (tx_n % B == B/2 && tx_n/B >= 1 && tx_n/B <= 8) dec[tx_n/B - 1] = TX;
          if (tx_n == 10*B) begin
            tx_act = 0; model_sent = 1; last_dec = dec;
          end
        end else begin
          chk("tx_idle", TX, 1);
          chk("resp_sent_idle", resp_sent, model_sent);
        end
        if (!tx_act && send_resp) begin
          tx_act = 1; tx_n = -1; frame = {1'b1, resp, 1'b0};
        end
        if (cmd_rdy && !prev_rdy) begin
          rise_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL cmd_rdy_unexpected actual=1 expected=0 t=%0t", $time);
          end else begin
            cur_pkt = exp_q.pop_front();
            have_pkt = 1;
            chk("cmd_at_rise", cmd, cur_pkt.c);
            chk("data_at_rise", data, cur_pkt.d);
          end
        end else if (cmd_rdy && have_pkt) begin
          chk("cmd_hold", cmd, cur_pkt.c);
          chk("data_hold", data, cur_pkt.d);
        end
        prev_rdy = cmd_rdy;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0; wait_cyc(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i]; wait_cyc(B);
    end
    RX = 1'b1; wait_cyc(B);
  endtask

  task automatic send_packet(input logic [7:0] c, input logic [15:0] d);
    exp_q.push_back({c, d});
    send_byte(c);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic pulse_send(input logic [7:0] r);
    resp = r; send_resp = 1'b1;
    wait_cyc(1);
    send_resp = 1'b0;
  endtask

  task automatic wait_sent(input string name);
    int k = 0;
    while (resp_sent !== 1'b1 && k < 12*B) begin
      wait_cyc(1); k++;
    end
    if (resp_sent !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%b expected=1", name, resp_sent);
    end
    wait_cyc(1);
  endtask

  initial begin
    int r0;
    rst = 1'b1; RX = 1'b1; send_resp = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    wait_cyc(3);
    chk("rst_tx", TX, 1);
    chk("rst_resp_sent", resp_sent, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_data", data, 0);
    rst = 1'b0;
    wait_cyc(4);

    // 1: basic packet
    send_packet(8'hA1, 16'hB2C3);
    wait_cyc(2);
    chk("t1_rdy", cmd_rdy, 1);
    chk("t1_cmd", cmd, 8'hA1);
    chk("t1_data", data, 16'hB2C3);
    chk("t1_rises", rise_cnt, 1);

    // 2: response A5
    pulse_send(8'hA5);
    wait_sent("t2");
    chk("t2_decoded", last_dec, 8'hA5);

    // 3: byte0 knocks down cmd_rdy
    exp_q.push_back({8'h23, 16'h0897});
    send_byte(8'h23);
    wait_cyc(1);
    chk("t3_rdy_low", cmd_rdy, 0);
    chk("t3_cmd_early", cmd, 8'h23);
    send_byte(8'h08);
    send_byte(8'h97);
    wait_cyc(2);
    chk("t3_rdy", cmd_rdy, 1);
    chk("t3_cmd", cmd, 8'h23);
    chk("t3_data", data, 16'h0897);

    // 4: response 46 concurrent with a packet (full duplex)
    fork
      begin pulse_send(8'h46); wait_sent("t4"); end
      send_packet(8'h77, 16'hABCD);
    join
    wait_cyc(2);
    chk("t4_decoded", last_dec, 8'h46);
    chk("t4_cmd", cmd, 8'h77);
    chk("t4_data", data, 16'hABCD);

    // busy send_resp is ignored
    pulse_send(8'h3C);
    wait_cyc(3*B);
    pulse_send(8'hFF);
    wait_sent("busy");
    chk("busy_decoded", last_dec, 8'h3C);
    wait_cyc(12*B);
    chk("busy_no_second", resp_sent, 1);

    // 5: clr_cmd_rdy
    clr_cmd_rdy = 1'b1; wait_cyc(1); clr_cmd_rdy = 1'b0; wait_cyc(1);
    chk("t5_rdy", cmd_rdy, 0);
    chk("t5_cmd", cmd, 8'h77);
    chk("t5_data", data, 16'hABCD);

    // set and clr in the same cycle: set wins for one cycle
    r0 = rise_cnt;
    clr_cmd_rdy = 1'b1;
    send_packet(8'h11, 16'h2233);
    wait_cyc(4);
    clr_cmd_rdy = 1'b0;
    chk("setwin_rise", rise_cnt - r0, 1);
    chk("setwin_cmd", cmd, 8'h11);
    chk("setwin_data", data, 16'h2233);
    chk("setwin_rdy_after", cmd_rdy, 0);

    // 6: reset during byte1 with a response in flight
    send_byte(8'hEE);
    pulse_send(8'h99);
    RX = 1'b0; wait_cyc(B);
    RX = 1'b1; wait_cyc(B);
    RX = 1'b0; wait_cyc(B/2);
    rst = 1'b1; RX = 1'b1;
    wait_cyc(3);
    chk("t6_tx", TX, 1);
    chk("t6_resp_sent", resp_sent, 0);
    chk("t6_rdy", cmd_rdy, 0);
    chk("t6_cmd", cmd, 0);
    chk("t6_data", data, 0);
    rst = 1'b0;
    wait_cyc(4);
    send_packet(8'h5A, 16'h1234);
    wait_cyc(2);
    chk("t6_rdy_new", cmd_rdy, 1);
    chk("t6_cmd_new", cmd, 8'h5A);
    chk("t6_data_new", data, 16'h1234);
    chk("t6_queue_empty", exp_q.size(), 0);
    wait_cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
